// File: rtl/fpcvt_rr_scheduler.sv
`timescale 1ns/1ps
// fpcvt_rr_scheduler
// Shares one 12-bit two's-complement -> {S,E,F} converter among NREQ requesters.
// A rotating-priority arbiter accepts one sample at a time, holds it for CONV_LAT
// cycles, then presents the registered result and requester id on a valid/ready port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_data    per-lane request valid and 12-bit sample (lane i at [12i+11:12i])
//   req_ready             one-hot accept strobe (combinational, IDLE only)
//   out_valid/out_ready   result handshake
//   out_s/out_e/out_f     converted sign, exponent, mantissa
//   out_id                lane that produced the result
//   busy                  transaction in flight
//   conv_count            completed transactions, wrapping
module fpcvt_rr_scheduler #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned CONV_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [12*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_s,
    output logic [2:0]         out_e,
    output logic [3:0]         out_f,
    output logic [IDW-1:0]     out_id,
    output logic               busy,
    output logic [15:0]        conv_count
);

    localparam int unsigned DW    = 12;
    localparam int unsigned CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0] id_reg, id_reg_nxt;
    logic [DW-1:0]  d_reg, d_reg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic           out_valid_nxt, out_s_nxt;
    logic [2:0]     out_e_nxt;
    logic [3:0]     out_f_nxt;
    logic [IDW-1:0] out_id_nxt;
    logic [15:0]    conv_count_nxt;

    // Rotating-priority grant: first valid lane scanning from rr_ptr upward.
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    int unsigned     scan_idx;
    logic [NREQ-1:0] scan_vec;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        scan_vec  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = 32'(rr_ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            scan_vec = req_valid >> scan_idx;
            if (!grant_any && scan_vec[0]) begin
                grant_any = 1'b1;
                grant     = NREQ'(1) << scan_idx;
                grant_id  = IDW'(scan_idx);
            end
        end
    end

    // Converter: magnitude, exponent from leading one, round half up, saturate.
    logic        cv_s;
    logic [11:0] cv_mag;
    logic [3:0]  cv_exp;
    logic [4:0]  cv_man;
    logic        cv_rnd;

    always_comb begin
        cv_s   = d_reg[11];
        cv_mag = cv_s ? 12'(~d_reg + 12'd1) : d_reg;
        if      (cv_mag[10]) cv_exp = 4'd7;
        else if (cv_mag[9])  cv_exp = 4'd6;
        else if (cv_mag[8])  cv_exp = 4'd5;
        else if (cv_mag[7])  cv_exp = 4'd4;
        else if (cv_mag[6])  cv_exp = 4'd3;
        else if (cv_mag[5])  cv_exp = 4'd2;
        else if (cv_mag[4])  cv_exp = 4'd1;
        else                 cv_exp = 4'd0;
        // exp==0 wraps the shift to 15, which yields a zero round bit.
        cv_rnd = 1'(cv_mag >> (cv_exp - 4'd1));
        cv_man = {1'b0, 4'(cv_mag >> cv_exp)} + {4'd0, cv_rnd};
        if (cv_man[4]) begin
            cv_man = 5'd8;
            cv_exp = cv_exp + 4'd1;
        end
        // Only -2048 has bit 11 set after negation; it saturates like exponent overflow.
        if (cv_mag[11] || (cv_exp > 4'd7)) begin
            cv_exp = 4'd7;
            cv_man = 5'd15;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        id_reg_nxt     = id_reg;
        d_reg_nxt      = d_reg;
        cnt_nxt        = cnt;
        out_valid_nxt  = out_valid;
        out_s_nxt      = out_s;
        out_e_nxt      = out_e;
        out_f_nxt      = out_f;
        out_id_nxt     = out_id;
        conv_count_nxt = conv_count;
        req_ready      = '0;
        case (state)
            IDLE: begin
                // Gated by rst_n so no accept strobe is shown while held in reset.
                req_ready = grant & {NREQ{rst_n}};
                if (grant_any) begin
                    d_reg_nxt  = DW'(req_data >> (DW * 32'(grant_id)));
                    id_reg_nxt = grant_id;
                    cnt_nxt    = CNT_W'(CONV_LAT - 1);
                    state_nxt  = CONV;
                end
            end
            CONV: begin
                if (cnt == '0) begin
                    out_s_nxt     = cv_s;
                    out_e_nxt     = cv_exp[2:0];
                    out_f_nxt     = cv_man[3:0];
                    out_id_nxt    = id_reg;
                    out_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_nxt  = 1'b0;
                    conv_count_nxt = conv_count + 16'd1;
                    state_nxt      = IDLE;
                    if (32'(id_reg) == NREQ - 1) begin
                        rr_ptr_nxt = '0;
                    end else begin
                        rr_ptr_nxt = id_reg + IDW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_reg     <= '0;
            d_reg      <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_s      <= 1'b0;
            out_e      <= '0;
            out_f      <= '0;
            out_id     <= '0;
            conv_count <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            id_reg     <= id_reg_nxt;
            d_reg      <= d_reg_nxt;
            cnt        <= cnt_nxt;
            out_valid  <= out_valid_nxt;
            out_s      <= out_s_nxt;
            out_e      <= out_e_nxt;
            out_f      <= out_f_nxt;
            out_id     <= out_id_nxt;
            conv_count <= conv_count_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fpcvt_rr_scheduler.sv
`timescale 1ns/1ps
// Testbench for fpcvt_rr_scheduler: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fpcvt_rr_scheduler;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int CONV_LAT = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [12*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic               out_s;
    logic [2:0]         out_e;
    logic [3:0]         out_f;
    logic [IDW-1:0]     out_id;
    logic               busy;
    logic [15:0]        conv_count;

    fpcvt_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CONV_LAT(CONV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_id(out_id),
        .busy(busy), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Value-level conversion: smallest exponent whose truncated mantissa fits 4 bits,
    // then round half up, renormalise, and clamp to the largest code.
    function automatic logic [7:0] ref_cvt(input logic [11:0] d);
        int v, a, e, f;
        v = int'($signed(d));
        a = (v < 0) ? -v : v;
        e = 0;
        while ((a >> e) >= 16) e++;
        f = (e > 0) ? ((a + (1 << (e - 1))) >> e) : a;
        if (f == 16) begin f = 8; e++; end
        if (e > 7) begin e = 7; f = 15; end
        return {d[11], 3'(e), 4'(f)};
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx = (ptr + k) % NREQ;
            if (((v >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (((v >> i) & 1) != 0) return i;
        return -1;
    endfunction

    function automatic logic [11:0] pick_data();
        case ($urandom_range(0, 7))
            0: return 12'h7FF;
            1: return 12'h800;
            2: return 12'h000;
            3: return 12'hFFF;
            default: return 12'($urandom);
        endcase
    endfunction

    // Reference model state.
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    logic [7:0]  m_res   = 8'h00;
    logic [15:0] m_count = 16'h0000;

    task automatic model_reset();
        m_busy = 1'b0; m_valid = 1'b0; m_left = 0; m_ptr = 0; m_id = 0; m_count = 16'h0000;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int g;
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            g = ref_grant(req_valid, m_ptr);
            if (g >= 0) begin
                m_busy = 1'b1;
                m_left = CONV_LAT;
                m_id   = g;
                m_res  = ref_cvt(12'(req_data >> (12 * g)));
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_ptr   = (m_id + 1) % NREQ;
            m_count = m_count + 16'd1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        if (cmp_en) begin
            g = ref_grant(req_valid, m_ptr);
            exp_rdy = (rst_n && !m_busy && g >= 0) ? NREQ'(1 << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("conv_count", 32'(conv_count), 32'(m_count));
            if (m_valid) begin
                chk("result", 32'({out_s, out_e, out_f}), 32'(m_res));
                chk("out_id", 32'(out_id), 32'(m_id));
            end
        end
    end

    task automatic set_lane(input int lane, input logic [11:0] d);
        req_data = (req_data & ~((12*NREQ)'(12'hFFF) << (12 * lane))) |
                   ((12*NREQ)'(d) << (12 * lane));
    endtask

    // Raise one lane, wait for its accept strobe, drop it after the accept edge.
    task automatic send(input int lane, input logic [11:0] d, output int acc_cyc);
        bit ok = 1'b0;
        acc_cyc = -1;
        @(posedge clk); #1;
        req_valid = req_valid | NREQ'(1 << lane);
        set_lane(lane, d);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (((req_ready >> lane) & 1) != 0) begin ok = 1'b1; acc_cyc = cyc; break; end
        end
        chk("accept_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = req_valid & ~NREQ'(1 << lane);
    endtask

    task automatic wait_result(output logic [7:0] res, output int id, output int oc);
        bit ok = 1'b0;
        res = 8'h00; id = -1; oc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; res = {out_s, out_e, out_f}; id = int'(out_id); oc = cyc; break; end
        end
        chk("out_valid_seen", 32'(ok), 32'd1);
    endtask

    // One complete transaction with out_ready high, checking result and id against literals.
    task automatic directed(input int lane, input logic [11:0] d, input logic [7:0] exp_res);
        int acc, oc, id;
        logic [7:0] res;
        send(lane, d, acc);
        wait_result(res, id, oc);
        chk("dir_result", 32'(res), 32'(exp_res));
        chk("dir_id", 32'(id), 32'(lane));
        chk("dir_latency", 32'(oc - acc), 32'(CONV_LAT + 1));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, oc, id, n, hs;
        int order [5];
        logic [7:0] res;

        rst_n = 1'b0; req_valid = '1; req_data = '0; out_ready = 1'b1;
        cmp_en = 1'b1;

        // Model pins against hand-computed codes.
        chk("pin_02C", 32'(ref_cvt(12'h02C)), 32'h2B);
        chk("pin_02E", 32'(ref_cvt(12'h02E)), 32'h2C);
        chk("pin_FFF", 32'(ref_cvt(12'hFFF)), 32'h81);
        chk("pin_800", 32'(ref_cvt(12'h800)), 32'hFF);
        chk("pin_7FF", 32'(ref_cvt(12'h7FF)), 32'h7F);
        chk("pin_01F", 32'(ref_cvt(12'h01F)), 32'h28);
        chk("pin_010", 32'(ref_cvt(12'h010)), 32'h18);

        // Reset state, with all lanes requesting.
        repeat (2) @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", 32'({out_s, out_e, out_f, out_id}), 32'd0);
        chk("rst_count", 32'(conv_count), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // Single request, then rounding / negative / saturation codes.
        directed(0, 12'h02C, 8'h2B);
        chk("count_after_first", 32'(conv_count), 32'd1);
        directed(1, 12'h02E, 8'h2C);
        directed(2, 12'hFFF, 8'h81);
        directed(3, 12'h800, 8'hFF);

        // Round-robin with all lanes continuously valid and data churning.
        @(posedge clk); #1;
        req_valid = '1;
        req_data = {pick_data(), pick_data(), pick_data(), pick_data()};
        n = 0;
        for (int t = 0; t < 100 && n < 5; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin order[n] = onehot_idx(req_ready); n++; end
            @(posedge clk); #1;
            req_data = {pick_data(), pick_data(), pick_data(), pick_data()};
            if (n == 5) req_valid = '0;
        end
        chk("rr_grants", 32'(n), 32'd5);
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(order[k]), 32'(k % NREQ));
        repeat (6) @(posedge clk);

        // Backpressure: result held while other lanes wait.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(0, 12'h7E0, acc);
        req_valid = 4'b1110;
        wait_result(res, id, oc);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'({out_s, out_e, out_f}), 32'h7F);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        req_valid = '0;
        hs = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
        end
        chk("bp_handshakes", 32'(hs), 32'd1);

        // Reset in the middle of a conversion.
        directed(1, 12'h155, ref_cvt(12'h155));
        send(2, 12'h3A5, acc);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_outs", 32'({out_s, out_e, out_f, out_id}), 32'd0);
        chk("mid_rst_count", 32'(conv_count), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);

        // Randomised traffic with random backpressure.
        for (int t = 0; t < 1500; t++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            req_data  = {pick_data(), pick_data(), pick_data(), pick_data()};
        end
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Counter wrap from a preloaded value.
        #2;
        force dut.conv_count = 16'hFFFE;
        m_count = 16'hFFFE;
        @(posedge clk); #2;
        release dut.conv_count;
        @(negedge clk);
        chk("wrap_preload", 32'(conv_count), 32'hFFFE);
        directed(3, 12'h123, ref_cvt(12'h123));
        chk("wrap_ffff", 32'(conv_count), 32'hFFFF);
        directed(0, 12'hF00, ref_cvt(12'hF00));
        chk("wrap_zero", 32'(conv_count), 32'h0000);

        repeat (3) @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
